// File: rtl/ppi_mode1_porta_handshake.sv
`default_nettype none
// ============================================================================
// Module      : ppi_mode1_porta_handshake
// Description : 8255-style Port A mode-1 strobed input/output handshake with
//               IBF/OBF_N/INTR/INTE status and bit set/reset of INTE.
// Revision    : 1.0 - initial release
// ============================================================================
module ppi_mode1_porta_handshake #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] A,
  input  logic       READ,
  input  logic       WRITE,
  input  logic [7:0] DATA_IN,
  input  logic [7:0] CONTROL_WORD,
  input  logic [7:0] PORTA_IN,
  input  logic       STB_N,
  input  logic       ACK_N,
  output logic [7:0] DATA_OUT,
  output logic [7:0] PORTA_OUT,
  output logic       PORTA_OE,
  output logic       IBF,
  output logic       OBF_N,
  output logic       INTR,
  output logic       INTE
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_IN_WAIT   = 3'd1,
    ST_IN_FULL   = 3'd2,
    ST_OUT_EMPTY = 3'd3,
    ST_OUT_FULL  = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_stbSync;
  logic [SYNC_STAGES-1:0] r_ackSync;
  logic                   r_stbHist;
  logic                   r_ackHist;
  logic                   r_readD;
  logic                   r_writeD;

  state_t     r_state;
  logic [7:0] r_dataOut;
  logic [7:0] r_portaOut;
  logic       r_portaOe;
  logic       r_ibf;
  logic       r_obfN;
  logic       r_intr;
  logic       r_inte;
  logic       r_ackSeen;

  state_t     w_stateNext;
  logic [7:0] w_dataOutNext;
  logic [7:0] w_portaOutNext;
  logic       w_ibfNext;
  logic       w_obfNNext;
  logic       w_intrNext;
  logic       w_inteNext;
  logic       w_ackSeenNext;

  logic w_stbNow;
  logic w_ackNow;
  logic w_stbFall;
  logic w_stbRise;
  logic w_ackFall;
  logic w_ackRise;
  logic w_addrA;
  logic w_addrCtl;
  logic w_readRise;
  logic w_readFall;
  logic w_wrRise;
  logic w_wrFall;
  logic w_modeSet;
  logic w_bsr;
  logic w_modeActive;
  logic w_dirIn;
  logic w_inteHit;
  logic w_unused;

  // Control word low bits select port B / port C modes, handled elsewhere.
  assign w_unused = &{1'b0, CONTROL_WORD[3:0]};

  assign w_stbNow  = r_stbSync[SYNC_STAGES-1];
  assign w_ackNow  = r_ackSync[SYNC_STAGES-1];
  assign w_stbFall = r_stbHist & ~w_stbNow;
  assign w_stbRise = ~r_stbHist & w_stbNow;
  assign w_ackFall = r_ackHist & ~w_ackNow;
  assign w_ackRise = ~r_ackHist & w_ackNow;

  assign w_addrA    = (A == 2'b00);
  assign w_addrCtl  = (A == 2'b11);
  assign w_readRise = READ & ~r_readD & w_addrA;
  assign w_readFall = ~READ & r_readD & w_addrA;
  assign w_wrRise   = WRITE & ~r_writeD;
  assign w_wrFall   = ~WRITE & r_writeD;

  assign w_modeSet    = w_wrRise & w_addrCtl & DATA_IN[7];
  assign w_bsr        = w_wrRise & w_addrCtl & ~DATA_IN[7];
  assign w_modeActive = CONTROL_WORD[7] & (CONTROL_WORD[6:5] == 2'b01);
  assign w_dirIn      = CONTROL_WORD[4];
  // INTE_A lives on PC4 in input mode and PC6 in output mode.
  assign w_inteHit    = w_bsr & w_modeActive &
                        (w_dirIn ? (DATA_IN[3:1] == 3'b100) : (DATA_IN[3:1] == 3'b110));

  always_comb begin
    w_stateNext    = r_state;
    w_dataOutNext  = r_dataOut;
    w_portaOutNext = r_portaOut;
    w_ibfNext      = r_ibf;
    w_obfNNext     = r_obfN;
    w_intrNext     = r_intr;
    w_inteNext     = r_inte;
    w_ackSeenNext  = r_ackSeen;

    if (w_modeSet) begin
      w_stateNext    = ST_IDLE;
      w_ibfNext      = 1'b0;
      w_intrNext     = 1'b0;
      w_inteNext     = 1'b0;
      w_obfNNext     = 1'b1;
      w_portaOutNext = 8'h00;
      w_ackSeenNext  = 1'b0;
    end else if (!w_modeActive) begin
      w_stateNext   = ST_IDLE;
      w_ibfNext     = 1'b0;
      w_obfNNext    = 1'b1;
      w_intrNext    = 1'b0;
      w_ackSeenNext = 1'b0;
    end else begin
      if (w_inteHit) begin
        w_inteNext = DATA_IN[0];
      end

      case (r_state)
        ST_IDLE: begin
          w_stateNext = w_dirIn ? ST_IN_WAIT : ST_OUT_EMPTY;
        end

        ST_IN_WAIT, ST_IN_FULL: begin
          if (!w_dirIn) begin
            w_stateNext = ST_IDLE;
            w_ibfNext   = 1'b0;
            w_intrNext  = 1'b0;
          end else if (r_state == ST_IN_WAIT) begin
            if (w_stbFall) begin
              w_dataOutNext = PORTA_IN;
              w_ibfNext     = 1'b1;
              w_stateNext   = ST_IN_FULL;
            end
          end else begin
            if (w_stbRise && r_inte) begin
              w_intrNext = 1'b1;
            end
            if (w_readRise) begin
              w_intrNext = 1'b0;
            end
            if (w_readFall) begin
              w_ibfNext   = 1'b0;
              w_stateNext = ST_IN_WAIT;
            end
            // A strobe landing on the read-fall cycle refills the latch.
            if (w_readFall && w_stbFall) begin
              w_dataOutNext = PORTA_IN;
              w_ibfNext     = 1'b1;
              w_stateNext   = ST_IN_FULL;
            end
            if (w_inteHit && DATA_IN[0] && w_stbNow) begin
              w_intrNext = 1'b1;
            end
          end
        end

        ST_OUT_EMPTY, ST_OUT_FULL: begin
          if (w_dirIn) begin
            w_stateNext = ST_IDLE;
            w_obfNNext  = 1'b1;
            w_intrNext  = 1'b0;
          end else begin
            if (r_state == ST_OUT_FULL) begin
              if (w_ackFall) begin
                w_obfNNext = 1'b1;
              end
              if (w_ackRise) begin
                if (r_inte) begin
                  w_intrNext = 1'b1;
                end
                w_ackSeenNext = 1'b1;
                w_stateNext   = ST_OUT_EMPTY;
              end
            end else if (w_inteHit && DATA_IN[0] && r_obfN && r_ackSeen) begin
              w_intrNext = 1'b1;
            end
            if (w_wrRise && w_addrA) begin
              w_portaOutNext = DATA_IN;
              w_intrNext     = 1'b0;
              w_ackSeenNext  = 1'b0;
            end
            if (w_wrFall && w_addrA) begin
              w_obfNNext  = 1'b0;
              w_stateNext = ST_OUT_FULL;
            end
          end
        end

        default: begin
          w_stateNext = ST_IDLE;
        end
      endcase

      if (!w_inteNext) begin
        w_intrNext = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stbSync  <= '1;
      r_ackSync  <= '1;
      r_stbHist  <= 1'b1;
      r_ackHist  <= 1'b1;
      r_readD    <= 1'b0;
      r_writeD   <= 1'b0;
      r_state    <= ST_IDLE;
      r_dataOut  <= 8'h00;
      r_portaOut <= 8'h00;
      r_portaOe  <= 1'b0;
      r_ibf      <= 1'b0;
      r_obfN     <= 1'b1;
      r_intr     <= 1'b0;
      r_inte     <= 1'b0;
      r_ackSeen  <= 1'b0;
    end else begin
      r_stbSync  <= {r_stbSync[SYNC_STAGES-2:0], STB_N};
      r_ackSync  <= {r_ackSync[SYNC_STAGES-2:0], ACK_N};
      r_stbHist  <= w_stbNow;
      r_ackHist  <= w_ackNow;
      r_readD    <= READ;
      r_writeD   <= WRITE;
      r_state    <= w_stateNext;
      r_dataOut  <= w_dataOutNext;
      r_portaOut <= w_portaOutNext;
      r_portaOe  <= w_modeActive & ~w_dirIn;
      r_ibf      <= w_ibfNext;
      r_obfN     <= w_obfNNext;
      r_intr     <= w_intrNext;
      r_inte     <= w_inteNext;
      r_ackSeen  <= w_ackSeenNext;
    end
  end

  assign DATA_OUT  = r_dataOut;
  assign PORTA_OUT = r_portaOut;
  assign PORTA_OE  = r_portaOe;
  assign IBF       = r_ibf;
  assign OBF_N     = r_obfN;
  assign INTR      = r_intr;
  assign INTE      = r_inte;

endmodule
`default_nettype wire

// File: tb/tb_ppi_mode1_porta_handshake.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppi_mode1_porta_handshake
// Description : Vector table with expected-output scoreboard plus hand-built
//               reset-abort sequence for ppi_mode1_porta_handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppi_mode1_porta_handshake;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] A;
  logic       READ;
  logic       WRITE;
  logic [7:0] DATA_IN;
  logic [7:0] CONTROL_WORD;
  logic [7:0] PORTA_IN;
  logic       STB_N;
  logic       ACK_N;
  logic [7:0] DATA_OUT;
  logic [7:0] PORTA_OUT;
  logic       PORTA_OE;
  logic       IBF;
  logic       OBF_N;
  logic       INTR;
  logic       INTE;

  ppi_mode1_porta_handshake #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .A(A), .READ(READ), .WRITE(WRITE),
    .DATA_IN(DATA_IN), .CONTROL_WORD(CONTROL_WORD), .PORTA_IN(PORTA_IN),
    .STB_N(STB_N), .ACK_N(ACK_N), .DATA_OUT(DATA_OUT), .PORTA_OUT(PORTA_OUT),
    .PORTA_OE(PORTA_OE), .IBF(IBF), .OBF_N(OBF_N), .INTR(INTR), .INTE(INTE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      nm;
    logic       rst;
    logic [1:0] a;
    logic       rd;
    logic       wr;
    logic [7:0] din;
    logic [7:0] cw;
    logic [7:0] pin;
    logic       stb;
    logic       ack;
    int         cyc;
    logic       chk;
    logic [20:0] exp;   // {DATA_OUT, PORTA_OUT, OE, IBF, OBF_N, INTR, INTE}
  } vec_t;

  vec_t        vecs[$];
  logic [20:0] expQ[$];
  int          total = 0;
  int          bad   = 0;

  function automatic vec_t mk(string nm, logic rst, logic [1:0] a, logic rd, logic wr,
                              logic [7:0] din, logic [7:0] cw, logic [7:0] pin,
                              logic stb, logic ack, int cyc, logic chk,
                              logic [7:0] dout, logic [7:0] pout, logic oe, logic ibf,
                              logic obfN, logic intr, logic inte);
    vec_t v;
    v.nm = nm; v.rst = rst; v.a = a; v.rd = rd; v.wr = wr; v.din = din;
    v.cw = cw; v.pin = pin; v.stb = stb; v.ack = ack; v.cyc = cyc; v.chk = chk;
    v.exp = {dout, pout, oe, ibf, obfN, intr, inte};
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    int       cnt;
    logic     sawIntr;
    logic [20:0] e;

    RESET = 1'b1; A = 2'b00; READ = 1'b0; WRITE = 1'b0; DATA_IN = 8'h00;
    CONTROL_WORD = 8'h00; PORTA_IN = 8'h00; STB_N = 1'b1; ACK_N = 1'b1;

    //                 name          rst a  rd wr din    cw     pin    stb ack cyc chk dout   pout   oe ibf obf intr inte
    vecs.push_back(mk("reset",        1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 2, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk("inModeEntry",  0, 0, 0, 0, 8'h00, 8'hB0, 8'h00, 1, 1, 2, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk("inteSetIn",    0, 3, 0, 1, 8'h09, 8'hB0, 8'h00, 1, 1, 1, 1, 8'h00, 8'h00, 0, 0, 1, 0, 1));
    vecs.push_back(mk("wrRelease",    0, 3, 0, 0, 8'h09, 8'hB0, 8'h00, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1));
    vecs.push_back(mk("stbLatch5A",   0, 0, 0, 0, 8'h09, 8'hB0, 8'h5A, 0, 1, 4, 1, 8'h5A, 8'h00, 0, 1, 1, 0, 1));
    vecs.push_back(mk("intrNotYet",   0, 0, 0, 0, 8'h09, 8'hB0, 8'h5A, 1, 1, 2, 1, 8'h5A, 8'h00, 0, 1, 1, 0, 1));
    vecs.push_back(mk("intrAfterStb", 0, 0, 0, 0, 8'h09, 8'hB0, 8'h5A, 1, 1, 1, 1, 8'h5A, 8'h00, 0, 1, 1, 1, 1));
    vecs.push_back(mk("readRise",     0, 0, 1, 0, 8'h09, 8'hB0, 8'h5A, 1, 1, 1, 1, 8'h5A, 8'h00, 0, 1, 1, 0, 1));
    vecs.push_back(mk("readFall",     0, 0, 0, 0, 8'h09, 8'hB0, 8'h5A, 1, 1, 1, 1, 8'h5A, 8'h00, 0, 0, 1, 0, 1));
    vecs.push_back(mk("stbLatch3C",   0, 0, 0, 0, 8'h09, 8'hB0, 8'h3C, 0, 1, 3, 1, 8'h3C, 8'h00, 0, 1, 1, 0, 1));
    vecs.push_back(mk("intr3C",       0, 0, 0, 0, 8'h09, 8'hB0, 8'h3C, 1, 1, 3, 1, 8'h3C, 8'h00, 0, 1, 1, 1, 1));
    vecs.push_back(mk("stbIgnoredFF", 0, 0, 0, 0, 8'h09, 8'hB0, 8'hFF, 0, 1, 3, 1, 8'h3C, 8'h00, 0, 1, 1, 1, 1));
    vecs.push_back(mk("stbRiseFull",  0, 0, 0, 0, 8'h09, 8'hB0, 8'hFF, 1, 1, 3, 1, 8'h3C, 8'h00, 0, 1, 1, 1, 1));
    vecs.push_back(mk("readRise2",    0, 0, 1, 0, 8'h09, 8'hB0, 8'hFF, 1, 1, 1, 1, 8'h3C, 8'h00, 0, 1, 1, 0, 1));
    vecs.push_back(mk("stbPending",   0, 0, 1, 0, 8'h09, 8'hB0, 8'h22, 0, 1, 2, 1, 8'h3C, 8'h00, 0, 1, 1, 0, 1));
    vecs.push_back(mk("coincident22", 0, 0, 0, 0, 8'h09, 8'hB0, 8'h22, 0, 1, 1, 1, 8'h22, 8'h00, 0, 1, 1, 0, 1));
    vecs.push_back(mk("stillFull",    0, 0, 0, 0, 8'h09, 8'hB0, 8'h22, 1, 1, 3, 1, 8'h22, 8'h00, 0, 1, 1, 1, 1));
    vecs.push_back(mk("inteClrIn",    0, 3, 0, 1, 8'h08, 8'hB0, 8'h22, 1, 1, 1, 1, 8'h22, 8'h00, 0, 1, 1, 0, 0));
    vecs.push_back(mk("wrRelease2",   0, 3, 0, 0, 8'h08, 8'hB0, 8'h22, 1, 1, 1, 0, 8'h22, 8'h00, 0, 1, 1, 0, 0));
    vecs.push_back(mk("inteSetFull",  0, 3, 0, 1, 8'h09, 8'hB0, 8'h22, 1, 1, 1, 1, 8'h22, 8'h00, 0, 1, 1, 1, 1));
    vecs.push_back(mk("wrRelease3",   0, 3, 0, 0, 8'h09, 8'hB0, 8'h22, 1, 1, 1, 0, 8'h22, 8'h00, 0, 1, 1, 1, 1));
    vecs.push_back(mk("modeSetOut",   0, 3, 0, 1, 8'hA0, 8'hA0, 8'h22, 1, 1, 1, 1, 8'h22, 8'h00, 1, 0, 1, 0, 0));
    vecs.push_back(mk("outEntry",     0, 3, 0, 0, 8'hA0, 8'hA0, 8'h22, 1, 1, 1, 1, 8'h22, 8'h00, 1, 0, 1, 0, 0));
    vecs.push_back(mk("inteSetOut",   0, 3, 0, 1, 8'h0D, 8'hA0, 8'h22, 1, 1, 1, 1, 8'h22, 8'h00, 1, 0, 1, 0, 1));
    vecs.push_back(mk("wrRelease4",   0, 3, 0, 0, 8'h0D, 8'hA0, 8'h22, 1, 1, 1, 0, 8'h22, 8'h00, 1, 0, 1, 0, 1));
    vecs.push_back(mk("write81Rise",  0, 0, 0, 1, 8'h81, 8'hA0, 8'h22, 1, 1, 1, 1, 8'h22, 8'h81, 1, 0, 1, 0, 1));
    vecs.push_back(mk("write81Fall",  0, 0, 0, 0, 8'h81, 8'hA0, 8'h22, 1, 1, 1, 1, 8'h22, 8'h81, 1, 0, 0, 0, 1));
    vecs.push_back(mk("ackFall",      0, 0, 0, 0, 8'h81, 8'hA0, 8'h22, 1, 0, 3, 1, 8'h22, 8'h81, 1, 0, 1, 0, 1));
    vecs.push_back(mk("ackRiseEarly", 0, 0, 0, 0, 8'h81, 8'hA0, 8'h22, 1, 1, 2, 1, 8'h22, 8'h81, 1, 0, 1, 0, 1));
    vecs.push_back(mk("ackRiseIntr",  0, 0, 0, 0, 8'h81, 8'hA0, 8'h22, 1, 1, 1, 1, 8'h22, 8'h81, 1, 0, 1, 1, 1));
    vecs.push_back(mk("write42Rise",  0, 0, 0, 1, 8'h42, 8'hA0, 8'h22, 1, 1, 1, 1, 8'h22, 8'h42, 1, 0, 1, 0, 1));
    vecs.push_back(mk("write42Fall",  0, 0, 0, 0, 8'h42, 8'hA0, 8'h22, 1, 1, 1, 1, 8'h22, 8'h42, 1, 0, 0, 0, 1));
    vecs.push_back(mk("overwrite55",  0, 0, 0, 1, 8'h55, 8'hA0, 8'h22, 1, 1, 1, 1, 8'h22, 8'h55, 1, 0, 0, 0, 1));
    vecs.push_back(mk("write55Fall",  0, 0, 0, 0, 8'h55, 8'hA0, 8'h22, 1, 1, 1, 1, 8'h22, 8'h55, 1, 0, 0, 0, 1));
    vecs.push_back(mk("resetMidOut",  1, 0, 0, 0, 8'h55, 8'hA0, 8'h22, 1, 1, 1, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk("modeSet80",    0, 3, 0, 1, 8'h80, 8'h80, 8'h22, 1, 1, 1, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk("strobesIgn",   0, 0, 0, 0, 8'h80, 8'h80, 8'h77, 0, 0, 4, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk("strobesIgn2",  0, 0, 0, 0, 8'h80, 8'h80, 8'h77, 1, 1, 4, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0));

    foreach (vecs[i]) begin
      RESET = vecs[i].rst; A = vecs[i].a; READ = vecs[i].rd; WRITE = vecs[i].wr;
      DATA_IN = vecs[i].din; CONTROL_WORD = vecs[i].cw; PORTA_IN = vecs[i].pin;
      STB_N = vecs[i].stb; ACK_N = vecs[i].ack;
      if (vecs[i].chk) expQ.push_back(vecs[i].exp);
      repeat (vecs[i].cyc) tick();
      if (vecs[i].chk) begin
        e = expQ.pop_front();
        check(vecs[i].nm, {11'd0, DATA_OUT, PORTA_OUT, PORTA_OE, IBF, OBF_N, INTR, INTE},
              {11'd0, e});
      end
    end

    // Reset while an input handshake is in flight: no INTR afterwards.
    RESET = 1'b1; tick();
    RESET = 1'b0; CONTROL_WORD = 8'hB0; tick(); tick();
    A = 2'b11; DATA_IN = 8'h09; WRITE = 1'b1; tick();
    WRITE = 1'b0; tick();
    A = 2'b00; PORTA_IN = 8'h99; STB_N = 1'b0;
    cnt = 0;
    while (IBF !== 1'b1 && cnt < 10) begin
      tick();
      cnt++;
    end
    check("stbLatency", cnt, 3);
    check("latch99", {24'd0, DATA_OUT}, 32'h99);
    RESET = 1'b1; STB_N = 1'b1; tick();
    RESET = 1'b0;
    sawIntr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (INTR === 1'b1) sawIntr = 1'b1;
    end
    check("noIntrAfterRst", {31'd0, sawIntr}, 32'd0);
    check("abortedIbf", {30'd0, IBF, INTE}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
